// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/read bus between the control unit and the multiply unit.
//   master (control unit): start, is_signed, a, b, rd_req, rd_sel
//   slave  (mdu_seq)     : rd_data, busy, stall, done
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, is_signed, a, b, rd_req, rd_sel,
    input  rd_data, busy, stall, done
  );

  modport slave (
    input  start, is_signed, a, b, rd_req, rd_sel,
    output rd_data, busy, stall, done
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: sequential radix-2 shift-add multiplier that owns HI/LO.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : start/is_signed/a/b  multiply request, operands taken on accept
//                  rd_req/rd_sel        MFHI/MFLO read, rd_data = rd_sel ? HI : LO
//                  busy                 state != IDLE
//                  stall                busy & (start | rd_req)
//                  done                 one-cycle pulse after HI/LO are written
// A multiply takes WIDTH RUN cycles on operand magnitudes plus one FIX cycle
// that applies the sign and commits {HI,LO} in one shot.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6   // 2**CNT_W must exceed WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  mdu_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     hi, lo;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 done_q;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic                 last_iter;

  // Magnitudes: negating the most negative value wraps back to itself, which
  // read as unsigned is exactly its magnitude.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Upper half plus conditional multiplicand; the carry becomes the new MSB
  // when the product shifts right.
  assign sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: if (bus.start) begin
          mcand  <= a_mag;
          mplier <= b_mag;
          neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          prod   <= '0;
          cnt    <= '0;
        end
        RUN: begin
          prod   <= {sum, prod[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: {hi, lo} <= neg ? -prod : prod;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.stall   = bus.busy & (bus.start | bus.rd_req);
  assign bus.done    = done_q;
  assign bus.rd_data = bus.rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .CNT_W(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Count busy cycles after the accepting edge; expect WIDTH+1 and a done pulse.
  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    while (bus.busy && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    chk({name, " busy_cycles"}, n, exp_cycles);
    chk({name, " done"}, {31'b0, bus.done}, 1);
  endtask

  task automatic read_chk(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0; #1;
    chk({name, " LO"}, bus.rd_data, lo);
    bus.rd_sel = 1'b1; #1;
    chk({name, " HI"}, bus.rd_data, hi);
    bus.rd_req = 1'b0;
  endtask

  // Called a little after a rising edge with the unit idle.
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b; #1;
    chk({name, " stall_on_accept"}, {31'b0, bus.stall}, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    wait_done(name, W + 1);
    read_chk(name, hi, lo);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    bus.rd_req = 1'b0; bus.rd_sel = 1'b0;

    vecs[0] = '{1'b0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[5] = '{1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[6] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A};
    vecs[7] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[8] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

    // Reset state
    #12;
    chk("rst busy",  {31'b0, bus.busy},  0);
    chk("rst done",  {31'b0, bus.done},  0);
    bus.rd_req = 1'b1; #1;
    chk("rst stall", {31'b0, bus.stall}, 0);
    read_chk("rst", 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MFHI one cycle after the accept stalls until the result is written.
    begin
      int n = 0;
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'h00010000; bus.b = 32'h00030000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.rd_req = 1'b1; bus.rd_sel = 1'b1; #1;
      while (bus.stall && n < 60) begin
        n++;
        @(posedge clk); #1;
      end
      chk("mfhi stall_cycles", n, 32);
      chk("mfhi data", bus.rd_data, 32'h3);
      bus.rd_req = 1'b0;
      @(posedge clk); #1;
    end

    // Second start held while busy, accepted in the first idle cycle.
    begin
      int n = 0;
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd100; bus.b = 32'd200;
      @(posedge clk); #1;
      bus.is_signed = 1'b1; bus.a = 32'hFFFFFFFE; bus.b = 32'd3; #1;
      while (bus.stall && n < 60) begin
        n++;
        @(posedge clk); #1;
      end
      chk("held stall_cycles", n, 33);
      chk("held done", {31'b0, bus.done}, 1);
      bus.rd_req = 1'b1; bus.rd_sel = 1'b0; #1;
      chk("held first LO", bus.rd_data, 32'h00004E20);
      chk("held idle stall", {31'b0, bus.stall}, 0);
      bus.rd_req = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("held accepted busy", {31'b0, bus.busy}, 1);
      wait_done("held op2", W + 1);
      read_chk("held op2", 32'hFFFFFFFF, 32'hFFFFFFFA);
      @(posedge clk); #1;
    end

    // Same-cycle read and start in idle: old value, no stall.
    run_op("pre", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    bus.rd_req = 1'b1; bus.rd_sel = 1'b0; #1;
    chk("same rd_data", bus.rd_data, 32'h2A);
    chk("same stall", {31'b0, bus.stall}, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rd_req = 1'b0;
    wait_done("same", W + 1);
    read_chk("same", 32'h0, 32'h0F);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst busy_before", {31'b0, bus.busy}, 1);
    #1 rst_n = 1'b0; #1;
    chk("midrst busy", {31'b0, bus.busy}, 0);
    chk("midrst done", {31'b0, bus.done}, 0);
    read_chk("midrst", 32'h0, 32'h0);
    bus.start = 1'b1; bus.rd_req = 1'b1; #1;
    chk("midrst stall", {31'b0, bus.stall}, 0);
    bus.start = 1'b0; bus.rd_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst busy", {31'b0, bus.busy}, 0);
    run_op("postrst", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequential multiply unit and HI/LO owner for the MIPS core.
- Replaces the combinational mult path with a radix-2 shift-add engine.
- Accepts MULT/MULTU from the control unit (HLwrite asserted, mult_to_reg low).
- Serves MFHI/MFLO reads, and asserts stall to the PC/pipeline while a multiply is in flight and an instruction needs the unit.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  multiply request (MULT/MULTU decoded this cycle)
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- a  input  WIDTH  rs operand; sampled on the accepting edge
- b  input  WIDTH  rt operand; sampled on the accepting edge
- rd_req  input  1  MFHI/MFLO in current instruction
- rd_sel  input  1  1 = HI (MFHI), 0 = LO (MFLO)
- rd_data  output  WIDTH  rd_sel ? HI : LO; combinational from registers
- busy  output  1  registered, high whenever state != IDLE
- stall  output  1  combinational: busy & (start | rd_req)
- done  output  1  one-cycle pulse in the first IDLE cycle after HI/LO are written

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; HI=0, LO=0; accumulator, multiplicand, multiplier, counter and sign flag all 0.
  - busy=0, done=0. stall=0 and rd_data=0 follow combinationally.
  - Reset mid-operation abandons the multiply; HI/LO read 0 afterwards.
- FSM states IDLE, RUN, FIX:
  - IDLE:
    - start=1 at edge E0 is accepted. Latch mcand=|a|, mplier=|b|; magnitudes only when is_signed=1, else raw.
    - Latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
    - Clear 2*WIDTH-bit product register and counter. Go to RUN.
    - done=0 except the post-write pulse.
  - RUN, one iteration per edge:
    - If mplier[0]=1, add mcand into the upper half of the product.
    - Shift product right by 1, capturing the adder carry into the MSB.
    - Shift mplier right by 1; counter+1.
    - On the edge where counter reaches WIDTH-1 (WIDTH iterations total, E1..E_WIDTH), go to FIX.
  - FIX:
    - One edge (E_WIDTH+1). {HI,LO} <= neg ? -product : product, two's-complement negate over 2*WIDTH bits.
    - Go to IDLE; done=1 for the following cycle.
- Latency: start accepted at E0; new HI/LO visible on rd_data after E(WIDTH+1), i.e. 33 edges for WIDTH=32. busy is high for WIDTH+1 cycles.
- Magnitude rule: |0x80000000| = 0x80000000 as an unsigned WIDTH-bit value. No overflow is possible because the product is 2*WIDTH bits.
- HI/LO change only on the FIX edge or reset; they are never partially updated.
- Requests while busy:
  - start while busy: not accepted, stall=1. Request must be held until busy falls; it is then accepted in the first IDLE cycle.
  - rd_req while busy: stall=1. rd_data shows old HI/LO and must be ignored by the consumer until stall drops. The first IDLE cycle returns the new result.
- start and rd_req in the same IDLE cycle: no stall. rd_data returns the pre-multiply HI/LO this cycle; start is accepted.
- start=0 in IDLE: state holds and all registers hold.
- is_signed, a and b are don't-care outside the accepting edge.

Test Plan:
- Unsigned basic: MULTU a=7, b=6 -> stall=0 on accept; busy=1 for 33 cycles; done pulse; then MFLO=0x0000002A, MFHI=0x00000000.
- Signed negative: MULT a=0xFFFFFFFF (-1), b=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. Repeat as MULTU -> HI=0x00000000, LO=0xFFFFFFFF.
- Extreme: MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0x00000000. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Hazards:
  - MFHI asserted 1 cycle after accept -> stall=1 for 32 cycles, then rd_data=new HI with stall=0.
  - Second start held during busy -> stall=1 until busy falls, then accepted with its own operands; its result is correct.
- Same-cycle read: HI/LO=0x0/0x2A from a prior op; start (3*5) and rd_req rd_sel=0 together in IDLE -> rd_data=0x2A, stall=0. After 33 edges LO=0x0F.
- Reset mid-op: rst_n low at RUN iteration 10 -> busy, done, HI, LO all 0 immediately (asynchronous). After release, idle with stall=0; a new MULTU 2*3 gives LO=6.
